// File: rtl/match_run_detector_if.sv
// Bundle of the sample stream, the lock/run status and the report handshake.
// The detector takes the slave side; the producer/consumer takes the master side.
interface match_run_detector_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             eq_in;
  logic [CNT_W-1:0] run_len;
  logic             locked;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_len;
  logic             rpt_sat;
  logic             rpt_drop;

  modport master (
    output in_valid, eq_in, rpt_ready,
    input  run_len, locked, rpt_valid, rpt_len, rpt_sat, rpt_drop
  );

  modport slave (
    input  in_valid, eq_in, rpt_ready,
    output run_len, locked, rpt_valid, rpt_len, rpt_sat, rpt_drop
  );
endinterface

// File: rtl/match_run_detector.sv
// Tracks runs of comparator matches, declares lock with mismatch hysteresis and
// emits each completed match run through a single-entry valid/ready register.
module match_run_detector #(
  parameter int CNT_W         = 8,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  match_run_detector_if.slave  bus
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_LOSING = 2'd2;

  localparam logic [CNT_W-1:0] RUN_MAX  = '1;
  localparam logic [CNT_W-1:0] LOCK_T   = CNT_W'(LOCK_THRESH);
  localparam logic [7:0]       UNLOCK_T = 8'(UNLOCK_THRESH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0] rpt_len_q, rpt_len_d;
  logic             rpt_sat_q, rpt_sat_d;
  logic             rpt_drop_q, rpt_drop_d;

  logic [CNT_W-1:0] run_inc;
  logic [7:0]       miss_inc;
  logic             new_rpt;
  logic             handshake;

  always_comb begin
    run_inc    = (run_len_q == RUN_MAX) ? RUN_MAX : run_len_q + CNT_W'(1);
    miss_inc   = miss_cnt_q + 8'd1;
    state_d    = state_q;
    run_len_d  = run_len_q;
    miss_cnt_d = miss_cnt_q;
    new_rpt    = 1'b0;

    if (bus.in_valid) begin
      if (bus.eq_in) begin
        run_len_d  = run_inc;
        miss_cnt_d = '0;
        case (state_q)
          ST_SEARCH: if (run_inc >= LOCK_T) state_d = ST_LOCKED;
          ST_LOSING: state_d = ST_LOCKED;
          ST_LOCKED: state_d = ST_LOCKED;
          default:   state_d = ST_SEARCH;
        endcase
      end else begin
        new_rpt   = (run_len_q != '0);
        run_len_d = '0;
        case (state_q)
          ST_LOCKED: begin
            if (UNLOCK_T == 8'd1) begin
              state_d    = ST_SEARCH;
              miss_cnt_d = '0;
            end else begin
              state_d    = ST_LOSING;
              miss_cnt_d = 8'd1;
            end
          end
          ST_LOSING: begin
            if (miss_inc == UNLOCK_T) begin
              state_d    = ST_SEARCH;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
          default: begin
            state_d    = ST_SEARCH;
            miss_cnt_d = '0;
          end
        endcase
      end
    end

    locked_d = (state_d == ST_LOCKED) || (state_d == ST_LOSING);
  end

  // A completing handshake frees the slot in time for a report formed on the same edge.
  always_comb begin
    handshake   = rpt_valid_q && bus.rpt_ready;
    rpt_valid_d = rpt_valid_q;
    rpt_len_d   = rpt_len_q;
    rpt_sat_d   = rpt_sat_q;
    rpt_drop_d  = rpt_drop_q;

    if (new_rpt) begin
      if (!rpt_valid_q || handshake) begin
        rpt_valid_d = 1'b1;
        rpt_len_d   = run_len_q;
        rpt_sat_d   = (run_len_q == RUN_MAX);
      end else begin
        rpt_drop_d  = 1'b1;
      end
    end else if (handshake) begin
      rpt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      run_len_q   <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_len_q   <= '0;
      rpt_sat_q   <= 1'b0;
      rpt_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_len_q   <= rpt_len_d;
      rpt_sat_q   <= rpt_sat_d;
      rpt_drop_q  <= rpt_drop_d;
    end
  end

  assign bus.run_len   = run_len_q;
  assign bus.locked    = locked_q;
  assign bus.rpt_valid = rpt_valid_q;
  assign bus.rpt_len   = rpt_len_q;
  assign bus.rpt_sat   = rpt_sat_q;
  assign bus.rpt_drop  = rpt_drop_q;

endmodule

// File: doc/match_run_detector.md
# match_run_detector

Sequential stage directly downstream of the 1-bit comparator. It consumes the comparator's per-cycle equality result `z`, qualified by a valid strobe, and tracks runs of consecutive matches. It declares lock after a programmable run of matches and drops lock after a programmable run of mismatches. Each completed match run is emitted as a length report over a valid/ready handshake for the next stage.

## Interface
- `CNT_W`, default 8: width of run-length counter and report.
- `LOCK_THRESH`, default 4: consecutive matches needed to enter LOCKED. Legal range 1..2^CNT_W-1.
- `UNLOCK_THRESH`, default 2: consecutive mismatches needed to leave lock. Legal range 1..255.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  qualifies `eq_in` this cycle.
- `eq_in`  in  1  comparator output `z`: 1 = inputs equal.
- `run_len`  out  CNT_W  current consecutive-match count, saturating.
- `locked`  out  1  high in LOCKED and LOSING states.
- `rpt_valid`  out  1  report holding-register occupied.
- `rpt_ready`  in  1  downstream accepts report.
- `rpt_len`  out  CNT_W  length of completed match run.
- `rpt_sat`  out  1  reported run saturated the counter.
- `rpt_drop`  out  1  sticky: a report was lost because the holding register was full.

## Operation
- States: SEARCH, LOCKED, LOSING. Reset state is SEARCH. Internal `miss_cnt` is 8 bits.
- Only cycles with `in_valid`=1 are samples. With `in_valid`=0, state and all counters hold.
- Sample with `eq_in`=1:
  - `run_len` increments, saturating at 2^CNT_W-1.
  - `miss_cnt` clears.
  - SEARCH -> LOCKED when the incremented `run_len` >= LOCK_THRESH.
  - LOSING -> LOCKED.
- Sample with `eq_in`=0:
  - If `run_len` > 0, a report {len=`run_len`, sat=(`run_len`==2^CNT_W-1)} is generated.
  - `run_len` clears.
  - LOCKED -> LOSING with `miss_cnt`=1. If UNLOCK_THRESH==1, LOCKED -> SEARCH directly.
  - In LOSING, `miss_cnt` increments. When the incremented value equals UNLOCK_THRESH, the state goes to SEARCH and `miss_cnt` clears.
  - In SEARCH, `miss_cnt` is unused and stays 0.
- Report holding register, single entry:
  - Handshake completes on a cycle with `rpt_valid` && `rpt_ready`.
  - Once `rpt_valid` is high, `rpt_len` and `rpt_sat` stay stable until the handshake completes.
  - New report while the register is empty: it loads.
  - New report in the same cycle as a completing handshake: the new report loads and `rpt_valid` stays 1. No drop.
  - New report while the register is full and no handshake completes: the new report is discarded, the held report is unchanged, and `rpt_drop` sets.
  - `rpt_drop` clears only on reset.
- A run in progress at reset is discarded and no report is issued.

## Timing
- All outputs are registered. A sample on rising edge N is reflected on the outputs after edge N. Latency is 1 cycle from sample to `run_len`, `locked`, and `rpt_valid`.
- `rst_n` sampled low at an edge: after that edge, state=SEARCH, `run_len`=0, `miss_cnt`=0, `locked`=0, `rpt_valid`=0, `rpt_len`=0, `rpt_sat`=0, `rpt_drop`=0.
- Reset overrides all inputs on the same edge, including a pending handshake and a sample. A report held at reset is lost and is not counted as a drop.
- `rpt_ready` is ignored while `rpt_valid`=0.
- `rpt_valid` deasserts the cycle after the handshake unless a new report loads on that same edge.
- Maximum report rate is one per two samples, because a run is at least one match followed by one mismatch. With `rpt_ready` tied high, no drops are possible.

## Test plan
Default parameters (CNT_W=8, LOCK_THRESH=4, UNLOCK_THRESH=2) unless stated.
- Reset: hold `rst_n`=0 for 3 cycles with random `in_valid`/`eq_in` -> all outputs 0 and state SEARCH. Release reset -> first match gives `run_len`=1 one cycle later.
- Lock entry: 4 valid matches -> `locked`=0 after 3 samples, `locked`=1 after the 4th, `run_len`=4. Insert `in_valid`=0 gaps between samples -> identical result, counts frozen during gaps.
- Lock hysteresis: after lock, apply mismatch, match, mismatch, mismatch -> `locked` sequence 1,1,1,0. Reports `rpt_len`=4, then `rpt_len`=1 if each is drained.
- Handshake: `rpt_ready`=0, then run of 5 matches then 1 mismatch -> `rpt_valid`=1, `rpt_len`=5, stable. Raise `rpt_ready` for one cycle -> `rpt_valid`=0 next cycle.
- Drop and simultaneity: hold `rpt_ready`=0 with a report pending, generate a run of 2 then a mismatch -> held `rpt_len` unchanged and `rpt_drop`=1. Separately, pulse `rpt_ready` on the same edge a new report forms -> new length loads and `rpt_drop` stays 0.
- Saturation: CNT_W=4, 20 matches then a mismatch -> `run_len` stops at 15 and the report has `rpt_len`=15, `rpt_sat`=1. Reset mid-run -> no report issued.
